// File: rtl/wave_nco_lut.sv
// Multi-channel NCO waveform generator: per-channel phase accumulators read a shared
// writable waveform table and emit one sample per channel per tick on a valid/ready stream.
module wave_nco_lut #(
  parameter int    CHANNELS  = 4,
  parameter int    PHASE_W   = 24,
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 21,
  parameter string INIT_FILE = "",
  localparam int   CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_en,
  input  logic               cfg_phase_clr,
  input  logic               lut_we,
  input  logic [ADDR_W-1:0]  lut_waddr,
  input  logic [DATA_W-1:0]  lut_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EMIT
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [PHASE_W-1:0]   r_phase [CHANNELS];
  logic [PHASE_W-1:0]   r_inc   [CHANNELS];
  logic [1:0]           r_mode  [CHANNELS];
  logic [CHANNELS-1:0]  r_en;

  logic [CH_W-1:0]      r_ch_idx;
  logic [DATA_W-1:0]    r_lut [2**ADDR_W];
  logic [DATA_W-1:0]    r_rdata;
  logic [DATA_W-1:0]    r_p_top;
  logic [1:0]           r_mode_l;
  logic                 r_en_l;
  logic                 r_overrun;

  logic [ADDR_W-1:0]    w_raddr;
  logic                 w_last;
  logic                 w_hs;
  logic [DATA_W-1:0]    w_data;

  assign w_raddr = r_phase[r_ch_idx][PHASE_W-1 -: ADDR_W];
  assign w_last  = (r_ch_idx == CH_W'(CHANNELS - 1));
  assign w_hs    = (r_state == S_EMIT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (tick) w_next = S_READ;
      S_READ: w_next = S_EMIT;
      S_EMIT: if (out_ready) w_next = w_last ? S_IDLE : S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_EMIT);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_idx <= '0;
    end else if ((r_state == S_IDLE) && tick) begin
      r_ch_idx <= '0;
    end else if (w_hs && !w_last) begin
      r_ch_idx <= r_ch_idx + CH_W'(1);
    end
  end

  // A phase clear on a config write wins over the same cycle's READ increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_phase[c] <= '0;
        r_inc[c]   <= '0;
        r_mode[c]  <= '0;
      end
      r_en <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c))) begin
          r_inc[c]  <= cfg_inc;
          r_mode[c] <= cfg_mode;
          r_en[c]   <= cfg_en;
        end
        if (cfg_we && (cfg_ch == CH_W'(c)) && cfg_phase_clr) begin
          r_phase[c] <= '0;
        end else if ((r_state == S_READ) && (r_ch_idx == CH_W'(c)) && r_en[c]) begin
          r_phase[c] <= r_phase[c] + r_inc[c];
        end
      end
    end
  end

  // Snapshot of the channel during READ keeps the emitted sample stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_top  <= '0;
      r_mode_l <= '0;
      r_en_l   <= 1'b0;
    end else if (r_state == S_READ) begin
      r_p_top  <= r_phase[r_ch_idx][PHASE_W-1 -: DATA_W];
      r_mode_l <= r_mode[r_ch_idx];
      r_en_l   <= r_en[r_ch_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (lut_we) begin
      r_lut[lut_waddr] <= lut_wdata;
    end
    if (r_state == S_READ) begin
      r_rdata <= r_lut[w_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= tick && (r_state != S_IDLE);
    end
  end

  always_comb begin
    w_data = '0;
    if (r_en_l) begin
      case (r_mode_l)
        2'd0: w_data = r_rdata;
        2'd1: w_data = r_p_top;
        2'd2: w_data = r_p_top[DATA_W-1] ? '0 : '1;
        2'd3: w_data = ~r_rdata;
        default: w_data = '0;
      endcase
    end
  end

  assign out_data = w_data;
  assign out_ch   = r_ch_idx;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_wave_nco_lut.sv
// Testbench for wave_nco_lut: table-driven waveform vectors plus hand-written
// timing, backpressure, overrun, reset and read-first sequences, checked via a scoreboard queue.
module tb_wave_nco_lut;

  localparam int CHANNELS = 4;
  localparam int PHASE_W  = 24;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 21;
  localparam int CH_W     = 2;
  localparam int NV       = 6;

  logic               clk;
  logic               rst_n;
  logic               tick;
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [PHASE_W-1:0] cfg_inc;
  logic [1:0]         cfg_mode;
  logic               cfg_en;
  logic               cfg_phase_clr;
  logic               lut_we;
  logic [ADDR_W-1:0]  lut_waddr;
  logic [DATA_W-1:0]  lut_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [DATA_W-1:0]  out_data;
  logic               busy;
  logic               overrun;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  typedef struct {
    int                    ch;
    logic [1:0]            mode;
    logic [PHASE_W-1:0]    inc;
    logic                  en;
    logic [3:0][DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs [NV];

  wave_nco_lut #(
    .CHANNELS (CHANNELS),
    .PHASE_W  (PHASE_W),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE("")
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_inc      (cfg_inc),
    .cfg_mode     (cfg_mode),
    .cfg_en       (cfg_en),
    .cfg_phase_clr(cfg_phase_clr),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ch       (out_ch),
    .out_data     (out_data),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted sample is matched against the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_sample: got ch=%0d data=%h expected no sample", out_ch, out_data);
      end else begin
        m_e = q.pop_front();
        checkOutput("sample_ch", 32'(out_ch), 32'(m_e.ch));
        checkOutput("sample_data", 32'(out_data), 32'(m_e.data));
      end
    end
  end

  task automatic pushScan(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                          input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
    exp_t e;
    e.ch = 2'd0; e.data = d0; q.push_back(e);
    e.ch = 2'd1; e.data = d1; q.push_back(e);
    e.ch = 2'd2; e.data = d2; q.push_back(e);
    e.ch = 2'd3; e.data = d3; q.push_back(e);
  endtask

  task automatic cfgWrite(input int ch, input logic [PHASE_W-1:0] inc, input logic [1:0] mode,
                          input logic en, input logic clr);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_inc = inc; cfg_mode = mode;
    cfg_en = en; cfg_phase_clr = clr;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_phase_clr = 1'b0;
  endtask

  task automatic configAll(input int ch, input logic [PHASE_W-1:0] inc, input logic [1:0] mode,
                           input logic en);
    for (int c = 0; c < CHANNELS; c++) begin
      if (c == ch) cfgWrite(c, inc, mode, en, 1'b1);
      else         cfgWrite(c, '0, 2'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic doTick();
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
  endtask

  task automatic waitIdle();
    bit done = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("scan_done", 32'(done), 32'd1);
    checkOutput("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic setVec(input int i, input int ch, input logic [1:0] mode, input logic [PHASE_W-1:0] inc,
                        input logic en, input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                        input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3);
    vecs[i].ch = ch; vecs[i].mode = mode; vecs[i].inc = inc; vecs[i].en = en;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2; vecs[i].exp[3] = e3;
  endtask

  task automatic applyStimulus(input int v);
    logic [DATA_W-1:0] d [CHANNELS];
    configAll(vecs[v].ch, vecs[v].inc, vecs[v].mode, vecs[v].en);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < CHANNELS; c++) d[c] = (c == vecs[v].ch) ? vecs[v].exp[k] : '0;
      pushScan(d[0], d[1], d[2], d[3]);
      doTick();
      waitIdle();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_mode = '0;
    cfg_en = 1'b0; cfg_phase_clr = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    out_ready = 1'b1;

    setVec(0, 0, 2'd0, 24'h010000, 1'b1, 21'h0,      21'h1000,   21'h2000,   21'h3000);
    setVec(1, 1, 2'd1, 24'h400000, 1'b1, 21'h0,      21'h080000, 21'h100000, 21'h180000);
    setVec(2, 2, 2'd2, 24'h800000, 1'b1, 21'h1FFFFF, 21'h0,      21'h1FFFFF, 21'h0);
    setVec(3, 2, 2'd3, 24'h800000, 1'b1, 21'h1FFFFF, 21'h17FFFF, 21'h1FFFFF, 21'h17FFFF);
    setVec(4, 3, 2'd1, 24'h123456, 1'b0, 21'h0,      21'h0,      21'h0,      21'h0);
    setVec(5, 3, 2'd0, 24'hFFFFFF, 1'b1, 21'h0,      21'hFF000,  21'hFF000,  21'hFF000);

    repeat (3) @(negedge clk);
    checkOutput("rst_valid",   32'(out_valid), 32'd0);
    checkOutput("rst_busy",    32'(busy),      32'd0);
    checkOutput("rst_data",    32'(out_data),  32'd0);
    checkOutput("rst_ch",      32'(out_ch),    32'd0);
    checkOutput("rst_overrun", 32'(overrun),   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < (1 << ADDR_W); i++) begin
      @(posedge clk); #1;
      lut_we = 1'b1; lut_waddr = ADDR_W'(i); lut_wdata = DATA_W'(i * 32'h1000);
    end
    @(posedge clk); #1; lut_we = 1'b0;

    // Latency: tick sampled at edge T -> READ, then EMIT for ch0, READ ch1, EMIT ch1.
    configAll(0, 24'h010000, 2'd0, 1'b1);
    pushScan(21'h0, 21'h0, 21'h0, 21'h0);
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(negedge clk);
    checkOutput("lat_read_valid", 32'(out_valid), 32'd0);
    checkOutput("lat_read_busy",  32'(busy),      32'd1);
    @(negedge clk);
    checkOutput("lat_ch0_valid",  32'(out_valid), 32'd1);
    checkOutput("lat_ch0_ch",     32'(out_ch),    32'd0);
    @(negedge clk);
    checkOutput("lat_read1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_ch1_valid",  32'(out_valid), 32'd1);
    checkOutput("lat_ch1_ch",     32'(out_ch),    32'd1);
    waitIdle();
    pushScan(21'h1000, 21'h0, 21'h0, 21'h0);
    doTick();
    waitIdle();

    for (int v = 0; v < NV; v++) applyStimulus(v);

    // Tick in the cycle of the final handshake is dropped.
    configAll(0, '0, 2'd2, 1'b1);
    pushScan(21'h1FFFFF, 21'h0, 21'h0, 21'h0);
    doTick();
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid && out_ch == 2'd3) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("last_ch_seen", 32'(found), 32'd1);
    tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(negedge clk);
    checkOutput("final_hs_overrun", 32'(overrun),   32'd1);
    checkOutput("final_hs_busy",    32'(busy),      32'd0);
    checkOutput("final_hs_valid",   32'(out_valid), 32'd0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("final_hs_noscan", 32'(busy), 32'd0);
    end
    checkOutput("final_hs_queue", 32'(q.size()), 32'd0);

    // Backpressure with a dropped tick and a config write during the stall.
    configAll(0, 24'h800000, 2'd2, 1'b1);
    pushScan(21'h1FFFFF, 21'h0, 21'h0, 21'h0);
    out_ready = 1'b0;
    doTick();
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("stall_valid_seen", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tick = (i == 1);
      cfg_we = (i == 3); cfg_ch = 2'd0; cfg_inc = '0; cfg_mode = 2'd0; cfg_en = 1'b1; cfg_phase_clr = 1'b0;
      @(negedge clk);
      checkOutput("stall_valid",   32'(out_valid), 32'd1);
      checkOutput("stall_ch",      32'(out_ch),    32'd0);
      checkOutput("stall_data",    32'(out_data),  32'h1FFFFF);
      checkOutput("stall_busy",    32'(busy),      32'd1);
      checkOutput("stall_overrun", 32'(overrun),   32'(i == 2));
    end
    @(posedge clk); #1;
    tick = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    waitIdle();
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checkOutput("stall_noscan", 32'(busy | out_valid), 32'd0);
    end

    // Asynchronous reset during READ of ch2; phases must restart from 0.
    configAll(0, 24'h200000, 2'd1, 1'b1);
    pushScan(21'h0, 21'h0, 21'h0, 21'h0);
    doTick();
    waitIdle();
    q.push_back('{ch: 2'd0, data: 21'h040000});
    q.push_back('{ch: 2'd1, data: 21'h0});
    doTick();
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid && out_ch == 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("ch1_before_reset", 32'(found), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy",  32'(busy),      32'd0);
    checkOutput("midrst_ch",    32'(out_ch),    32'd0);
    checkOutput("midrst_data",  32'(out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_queue", 32'(q.size()), 32'd0);
    cfgWrite(0, 24'h200000, 2'd1, 1'b1, 1'b0);
    pushScan(21'h0, 21'h0, 21'h0, 21'h0);
    doTick();
    waitIdle();
    pushScan(21'h040000, 21'h0, 21'h0, 21'h0);
    doTick();
    waitIdle();

    // Table write to the address being read in the same cycle returns old data.
    configAll(0, '0, 2'd0, 1'b1);
    pushScan(21'h0, 21'h0, 21'h0, 21'h0);
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    lut_we = 1'b1; lut_waddr = '0; lut_wdata = 21'h12345;
    @(posedge clk); #1; lut_we = 1'b0;
    waitIdle();
    pushScan(21'h12345, 21'h0, 21'h0, 21'h0);
    doTick();
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
